// File: rtl/fp_mult_arbiter_if.sv
// Requester and multiplier bus of the shared-multiplier arbiter.
// The slave modport is the arbiter; the master modport is the lane/multiplier side.
interface fp_mult_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 32
);
   logic [NUM_REQ-1:0]    reqValidIn;
   logic [NUM_REQ-1:0]    reqReadyOut;
   logic [NUM_REQ*DW-1:0] reqDataAIn;
   logic [NUM_REQ*DW-1:0] reqDataBIn;
   logic [DW-1:0]         multDataAOut;
   logic [DW-1:0]         multDataBOut;
   logic                  multValidOut;
   logic [DW-1:0]         multDataIn;
   logic [NUM_REQ-1:0]    respValidOut;
   logic [DW-1:0]         respDataOut;

   modport slave (
      input  reqValidIn, reqDataAIn, reqDataBIn, multDataIn,
      output reqReadyOut, multDataAOut, multDataBOut, multValidOut,
      output respValidOut, respDataOut
   );

   modport master (
      output reqValidIn, reqDataAIn, reqDataBIn, multDataIn,
      input  reqReadyOut, multDataAOut, multDataBOut, multValidOut,
      input  respValidOut, respDataOut
   );
endinterface

// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one FP multiplier among NUM_REQ requesters; a tag pipeline routes
// each product back to its owner. FP_MULT_ARB_STATS_EN adds grant/busy statistics counters.
module fp_mult_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int FRAC_WIDTH   = 23,
   parameter int EXP_WIDTH    = 8,
   parameter int MULT_LATENCY = 1
) (
   input  logic clkIn,
   input  logic rstIn,
   input  logic enableIn,
   fp_mult_arbiter_if.slave bus,
   output logic busyOut
`ifdef FP_MULT_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] statsOut,
   output logic [31:0]           statsBusyCyc
`endif
);
   localparam int DW   = FRAC_WIDTH + EXP_WIDTH + 1;
   localparam int IDW  = $clog2(NUM_REQ);
   localparam int LAST = MULT_LATENCY;

   logic [IDW-1:0] rrPtr;
   logic [IDW-1:0] rrPtrNext;
   logic           grantValid;
   logic [IDW-1:0] grantId;
   logic           handshake;
   logic [DW-1:0]  grantDataA;
   logic [DW-1:0]  grantDataB;
   logic [LAST:0]  tagValid;
   logic [IDW-1:0] tagId [0:LAST];

   function automatic logic [IDW-1:0] wrapAdd(input logic [IDW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IDW'(sum);
   endfunction

   function automatic logic [NUM_REQ-1:0] oneHot(input logic [IDW-1:0] id);
      logic [NUM_REQ-1:0] vec;
      vec     = '0;
      vec[id] = 1'b1;
      return vec;
   endfunction

   // Scan downward so the candidate closest to rrPtr is the last (winning) assignment.
   always_comb begin
      grantValid = 1'b0;
      grantId    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.reqValidIn[wrapAdd(rrPtr, k)]) begin
            grantValid = 1'b1;
            grantId    = wrapAdd(rrPtr, k);
         end
      end
   end

   assign handshake       = grantValid & enableIn;
   assign bus.reqReadyOut = handshake ? oneHot(grantId) : '0;
   assign grantDataA      = bus.reqDataAIn[int'(grantId)*DW +: DW];
   assign grantDataB      = bus.reqDataBIn[int'(grantId)*DW +: DW];
   assign rrPtrNext       = (int'(grantId) == NUM_REQ - 1) ? '0 : grantId + 1'b1;

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         bus.multValidOut <= 1'b0;
         bus.multDataAOut <= '0;
         bus.multDataBOut <= '0;
         rrPtr            <= '0;
      end else begin
         bus.multValidOut <= handshake;
         if (handshake) begin
            bus.multDataAOut <= grantDataA;
            bus.multDataBOut <= grantDataB;
            rrPtr            <= rrPtrNext;
         end
      end
   end

   // Owner tags travel alongside the multiplier; the tail lines up with multDataIn.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         tagValid <= '0;
         for (int s = 0; s <= LAST; s++) tagId[s] <= '0;
      end else begin
         tagValid[0] <= handshake;
         tagId[0]    <= grantId;
         for (int s = 1; s <= LAST; s++) begin
            tagValid[s] <= tagValid[s-1];
            tagId[s]    <= tagId[s-1];
         end
      end
   end

   assign bus.respValidOut = tagValid[LAST] ? oneHot(tagId[LAST]) : '0;
   assign bus.respDataOut  = bus.multDataIn;
   assign busyOut          = |tagValid;

`ifdef FP_MULT_ARB_STATS_EN
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gStats
      logic [15:0] grantCnt;
      always_ff @(posedge clkIn or posedge rstIn) begin
         if (rstIn) begin
            grantCnt <= '0;
         end else if (handshake && grantId == IDW'(gi) && grantCnt != 16'hFFFF) begin
            grantCnt <= grantCnt + 16'd1;
         end
      end
      assign statsOut[gi*16 +: 16] = grantCnt;
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) statsBusyCyc <= '0;
      else if (busyOut) statsBusyCyc <= statsBusyCyc + 32'd1;
   end
`endif
endmodule
